// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among several burst producers.
// A grant lasts until the owner's last word, the burst-length cap, or the owner
// dropping its request; priority then rotates to the index after the owner.
module fifo_write_arbiter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic [REQUESTERS-1:0]         req,
  input  logic [WIDTH-1:0]              din [REQUESTERS],
  input  logic [REQUESTERS-1:0]         last,
  output logic [REQUESTERS-1:0]         ack,
  output logic [WIDTH-1:0]              fifo_din,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  output logic [$clog2(REQUESTERS)-1:0] owner,
  output logic                          busy
);

  localparam int unsigned OwW = $clog2(REQUESTERS);
  localparam int unsigned BcW = $clog2(MAX_BURST + 1);

  localparam logic [OwW-1:0] LastIdx = OwW'(REQUESTERS - 1);
  localparam logic [BcW-1:0] BcMax   = BcW'(MAX_BURST - 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [OwW-1:0] owner_q, owner_d;
  logic [OwW-1:0] ptr_q, ptr_d;
  logic [BcW-1:0] bcnt_q, bcnt_d;

  logic           win_found;
  logic [OwW-1:0] win_idx;
  logic           rel_burst;

  // First requester at or above ptr, wrapping modulo REQUESTERS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < int'(REQUESTERS); k++) begin
      if (!win_found && req[(int'(ptr_q) + k) % int'(REQUESTERS)]) begin
        win_found = 1'b1;
        win_idx   = OwW'((int'(ptr_q) + k) % int'(REQUESTERS));
      end
    end
  end

  // Write-port outputs; reset suppresses any write in the same cycle.
  always_comb begin
    ack      = '0;
    fifo_din = '0;
    busy     = 1'b0;
    if (state_q == StGrant && !srst) begin
      busy     = 1'b1;
      fifo_din = din[owner_q];
      if (req[owner_q] && !fifo_full) begin
        ack[owner_q] = 1'b1;
      end
    end
    fifo_wr_en = |ack;
  end

  // Next-state: grant selection, burst counting, release and pointer rotation.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    bcnt_d    = bcnt_q;
    rel_burst = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          owner_d = win_idx;
          bcnt_d  = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!req[owner_q]) begin
          // Owner walked away mid-burst: treat the burst as finished.
          rel_burst = 1'b1;
        end else if (ack[owner_q]) begin
          if (last[owner_q] || bcnt_q == BcMax) begin
            rel_burst = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        // A full FIFO leaves everything holding, even with last asserted.
        if (rel_burst) begin
          state_d = StIdle;
          bcnt_d  = '0;
          ptr_d   = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign owner = owner_q;

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-port arbiter that shares a single FIFO write port among `REQUESTERS` producers. Each producer pushes bursts of words. A burst ends on `last` or when the `MAX_BURST` cap is reached. The arbiter holds the grant for the whole burst, stalls on `fifo_full`, and rotates priority after every burst. It sits directly in front of the team's fifo write side (`din`/`wr_en`/`full`) and replaces per-producer FIFOs where one shared buffer is enough.

## Interface
Parameters:
- `WIDTH`, 8, data word width.
- `REQUESTERS`, 4, number of producers; legal range 2..8.
- `MAX_BURST`, 4, maximum words per grant before forced rotation; legal range 1..16.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `srst`, input, 1, synchronous active-high reset.
- `req`, input, `REQUESTERS`, per-producer request; the producer holds it high while it has a word presented.
- `din`, input, `WIDTH` × `REQUESTERS` (unpacked array), per-producer data word.
- `last`, input, `REQUESTERS`, marks the presented word as the final word of the burst.
- `ack`, output, `REQUESTERS`, one-hot; high means the word on `din[i]` is written this cycle.
- `fifo_din`, output, `WIDTH`, data to the FIFO write port.
- `fifo_wr_en`, output, 1, FIFO write enable.
- `fifo_full`, input, 1, FIFO full flag.
- `owner`, output, `$clog2(REQUESTERS)`, index of the current or most recent grantee.
- `busy`, output, 1, high while in GRANT.

## Operation
- Registered state: `state` (IDLE/GRANT), `owner`, round-robin pointer `ptr`, burst counter `bcnt` (width `$clog2(MAX_BURST+1)`).
- **IDLE:**
  - `ack` = 0.
  - If `|req`, the winner is the first `i` with `req[i]` set, searching upward from `ptr` and wrapping modulo `REQUESTERS`.
  - Next edge: `owner` ← winner, `bcnt` ← 0, `state` ← GRANT.
  - If no `req` is set, remain in IDLE.
- **GRANT:**
  - `ack[owner]` = `req[owner] && !fifo_full && !srst`; all other `ack` bits are 0.
  - `fifo_wr_en` = `|ack`.
  - `fifo_din` = `din[owner]` in GRANT, 0 otherwise.
- **Transfer cycle** (`ack[owner]` = 1):
  - If `last[owner]` or `bcnt == MAX_BURST-1`, release: `state` ← IDLE, `ptr` ← (`owner`+1) mod `REQUESTERS`, `bcnt` ← 0.
  - Otherwise `bcnt` ← `bcnt`+1.
- **Stall** (`req[owner] && fifo_full`): no write; `bcnt`, `owner` and `state` hold.
- **Abandon** (`!req[owner]` in GRANT): no write; release exactly as in the transfer case. The burst is considered ended.
- `last` is only sampled on a transfer cycle; `last` on a non-owner is ignored.
- **Pointer wrap:** `owner` = `REQUESTERS-1` sets `ptr` to 0. Arithmetic is modulo `REQUESTERS`, including non-power-of-2 values.
- The FIFO never receives a write while `fifo_full` = 1. `fifo_full` is used combinationally in the same cycle; no lookahead is required.

## Timing
- **Reset:**
  - `srst` high at an edge sets `state` = IDLE, `ptr` = 0, `owner` = 0, `bcnt` = 0.
  - While `srst` is high: `ack` = 0, `fifo_wr_en` = 0, `fifo_din` = 0, `busy` = 0.
  - Reset mid-burst drops the grant with no further write. The producer must re-request.
- **Grant latency:** `req` first seen high in IDLE during cycle n gives the earliest `ack` in cycle n+1.
- **Throughput:** one word per cycle inside a burst. There is exactly one IDLE cycle between bursts, including back-to-back bursts by different producers. Peak occupancy is `MAX_BURST`/(`MAX_BURST`+1).
- **Handshake:** a word is consumed on the rising edge ending a cycle with `ack[i]` = 1. The producer may change `din`/`last` after that edge. `req` may deassert only after an acked word; deasserting mid-burst is an abandon.
- **Fairness:** with all requesters active, each waits at most `REQUESTERS-1` bursts, i.e. at most (`REQUESTERS`-1)·(`MAX_BURST`+1) cycles plus stall cycles.
- **Simultaneous events:**
  - `fifo_full` and `last` in the same cycle: stall; the burst stays open.
  - `srst` with a would-be transfer: reset wins and no write occurs.

## Test plan
- **Single burst** (`REQUESTERS`=4, `MAX_BURST`=4): `req[2]`=1 from cycle 0 with words 0xA1, 0xA2, 0xA3, `last` on 0xA3 → `ack[2]` and `fifo_wr_en` high in cycles 1–3; `fifo_din` = A1, A2, A3; `owner` = 2; IDLE in cycle 4; `ptr` = 3.
- **Round robin:** all `req` held, `last` never set → `owner` sequence 0, 1, 2, 3, 0; 4 words each; one IDLE cycle between bursts; 16 words in 20 cycles.
- **Full stall:** requester 1 bursts 4 words; `fifo_full` = 1 for 2 cycles after word 2 → `ack` and `fifo_wr_en` = 0 for those cycles, `bcnt` holds, all 4 words written, release after word 4.
- **Abandon:** `req[1]` drops after 1 acked word while `req[3]` pending → release; `ptr` = 2; requester 3 wins; its first `ack` arrives 2 cycles after the drop.
- **Reset mid-burst:** `srst` pulsed while requester 2 is on word 2 of 4 → `ack` = 0 in the reset cycle; `owner` = 0, `ptr` = 0 after reset; with `req[0]` and `req[2]` both high, requester 0 wins.
- **Wrap:** `REQUESTERS`=3, requester 2 finishes a burst with `req[0]` and `req[1]` pending → `ptr` = 0; requester 0 is granted next.
